exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Parametrised, sequential exception controller between the EX stage and data memory.
//  - Same-cycle gating: suppresses memory read/write on any unmasked fatal ALU flag.
//  - Captures the cause and the faulting PC.
//  - Sequences the pipeline: flush, vector to the handler, return on ERET.
//  - Counts taken exceptions and detects faults raised while one is already in progress.
// PARAMETERS
//  STATUS_W     8             width of ALU status vector
//  ADDR_W       32            PC / address width
//  FATAL_MASK   8'b0100_1100  status bits treated as fatal (bits 6,3,2)
//  VECTOR_ADDR  32'h0000_0080 handler entry address
//  FLUSH_CYCLES 2             cycles flush is held high (>=1)
//  COUNT_W      8             width of exception counter
// PORTS
//  clk          in  1        rising-edge clock
//  rst_n        in  1        asynchronous, active-low reset
//  alu_status   in  STATUS_W ALU flag vector for the instruction in EX
//  status_valid in  1        alu_status belongs to a live instruction
//  pc_in        in  ADDR_W   PC of the instruction in EX
//  mem_read_in  in  1        decoded memory read request
//  mem_write_in in  1        decoded memory write request
//  eret         in  1        exception-return strobe from decode
//  cfg_we       in  1        write enable for runtime enable mask
//  cfg_mask     in  STATUS_W new runtime enable mask
//  mem_read     out 1        gated memory read
//  mem_write    out 1        gated memory write
//  flush        out 1        kill in-flight pipeline stages
//  redirect     out 1        one-cycle PC redirect strobe
//  redirect_pc  out ADDR_W   redirect target
//  epc          out ADDR_W   captured faulting PC
//  cause        out STATUS_W captured fatal flags
//  in_handler   out 1        high in HANDLER state
//  double_fault out 1        sticky: fault seen outside IDLE
//  exc_count    out COUNT_W  saturating count of taken exceptions
// BEHAVIOUR
//  Fault detection and gating:
//  - fault = status_valid & |(alu_status & FATAL_MASK & en_mask); combinational.
//  - Reset (async, rst_n low), values held until first clk edge after release:
//    - state=IDLE, en_mask=all ones, epc=0, cause=0, exc_count=0, double_fault=0.
//    - flush=0, redirect=0, redirect_pc=0.
//    - mem_read=mem_write=0 while rst_n low.
//  - mem_read  = mem_read_in  & ~fault & (state==IDLE | state==HANDLER); same cycle, 0 latency.
//  - mem_write follows the same rule with mem_write_in.
//  - cfg_we: en_mask<=cfg_mask at the clk edge; the fault test in that cycle uses the old mask.
//  FSM states IDLE, FLUSH, VECTOR, HANDLER, RETURN:
//  - IDLE: on fault, at the clk edge:
//    - epc<=pc_in, cause<=alu_status & FATAL_MASK & en_mask.
//    - exc_count<=exc_count+1, saturating at all ones.
//    - flush counter<=FLUSH_CYCLES-1; go FLUSH.
//    - eret in IDLE is ignored.
//  - FLUSH: flush=1; counter decrements each cycle; at counter==0 go VECTOR.
//    - flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the fault.
//  - VECTOR: redirect=1, redirect_pc=VECTOR_ADDR for exactly one cycle; go HANDLER.
//  - HANDLER: in_handler=1; memory passes through subject to fault gating.
//    - On eret go RETURN; epc and cause stay readable.
//  - RETURN: redirect=1 for one cycle; redirect_pc=epc+4, modulo 2^ADDR_W; go IDLE.
//  Boundary rules:
//  - Fault in FLUSH/VECTOR/HANDLER/RETURN: double_fault<=1 (sticky until reset).
//    - It does not recapture epc/cause, does not increment exc_count, does not change state.
//    - Memory is still gated that cycle.
//  - eret and fault in the same HANDLER cycle: go RETURN and set double_fault.
//  - Reset mid-sequence: immediate return to IDLE, all outputs to reset values.
//  - Outside FLUSH/VECTOR/RETURN: flush=0, redirect=0, redirect_pc holds last value.
// TESTING
//  1 Pass-through: IDLE, status=0, rd_in=1 -> mem_read=1 same cycle; state stays IDLE; exc_count=0.
//  2 Overflow fault:
//    - Stimulus: status=8'h40, valid, pc=32'h100, wr_in=1.
//    - Same cycle: mem_write=0.
//    - After the clk edge: epc=32'h100, cause=8'h40.
//    - flush=1 for 2 cycles, then redirect=1 with redirect_pc=32'h80 for 1 cycle, then in_handler=1.
//  3 Return: in HANDLER, pulse eret -> next cycle redirect=1, redirect_pc=32'h104; then IDLE.
//  4 Masking:
//    - cfg_mask=8'hBF written, then status=8'h40 -> no fault, memory passes.
//    - status=8'h08 -> fault, cause=8'h08.
//  5 Double fault: status=8'h04 during FLUSH -> double_fault=1; epc unchanged; exc_count stays 1.
//  6 Reset/saturation:
//    - rst_n low during FLUSH -> all outputs 0 immediately.
//    - 256 faults with COUNT_W=8 -> exc_count holds 8'hFF.

Source files
------------

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - EX-to-memory exception controller: fault gating, cause/EPC capture, flush/vector/return sequencing.
module exception_ctrl #(
  parameter int                  STATUS_W     = 8,
  parameter int                  ADDR_W       = 32,
  parameter logic [STATUS_W-1:0] FATAL_MASK   = 8'b0100_1100,
  parameter logic [ADDR_W-1:0]   VECTOR_ADDR  = 32'h0000_0080,
  parameter int                  FLUSH_CYCLES = 2,
  parameter int                  COUNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATUS_W-1:0] alu_status,
  input  logic                status_valid,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                eret,
  input  logic                cfg_we,
  input  logic [STATUS_W-1:0] cfg_mask,
  output logic                mem_read,
  output logic                mem_write,
  output logic                flush,
  output logic                redirect,
  output logic [ADDR_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0]   epc,
  output logic [STATUS_W-1:0] cause,
  output logic                in_handler,
  output logic                double_fault,
  output logic [COUNT_W-1:0]  exc_count
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [STATUS_W-1:0] en_mask;
  logic [STATUS_W-1:0] fatal_bits;
  logic                fault;
  logic                mem_pass;
  logic [CNT_W-1:0]    flush_cnt;
  logic [ADDR_W-1:0]   redirect_pc_q;

  assign fatal_bits = alu_status & FATAL_MASK & en_mask;
  assign fault      = status_valid & (|fatal_bits);

  // rst_n in the gate forces memory requests low for the whole reset interval.
  assign mem_read  = rst_n & mem_read_in  & ~fault & mem_pass;
  assign mem_write = rst_n & mem_write_in & ~fault & mem_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = redirect_pc_q;
    in_handler  = 1'b0;
    mem_pass    = 1'b0;
    case (state)
      IDLE: begin
        mem_pass = 1'b1;
        if (fault) state_next = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == '0) state_next = VECTOR;
      end
      VECTOR: begin
        redirect    = 1'b1;
        redirect_pc = VECTOR_ADDR;
        state_next  = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        mem_pass   = 1'b1;
        if (eret) state_next = RETURN;
      end
      RETURN: begin
        redirect    = 1'b1;
        redirect_pc = epc + ADDR_W'(4);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Faults outside IDLE only mark double_fault; the captured context is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_mask       <= '1;
      epc           <= '0;
      cause         <= '0;
      exc_count     <= '0;
      double_fault  <= 1'b0;
      flush_cnt     <= '0;
      redirect_pc_q <= '0;
    end else begin
      redirect_pc_q <= redirect_pc;
      if (cfg_we) en_mask <= cfg_mask;
      if (state == IDLE && fault) begin
        epc       <= pc_in;
        cause     <= fatal_bits;
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
        if (exc_count != '1) exc_count <= exc_count + COUNT_W'(1);
      end else if (fault) begin
        double_fault <= 1'b1;
      end
      if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - scoreboard bench for exception_ctrl with a cycle-timeline reference model.
module tb_exception_ctrl;

  localparam int          F     = 2;
  localparam logic [7:0]  FATAL = 8'b0100_1100;
  localparam logic [31:0] VEC   = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  alu_status = '0;
  logic        status_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0, eret = 1'b0, cfg_we = 1'b0;
  logic [7:0]  cfg_mask = '0;
  logic        mem_read, mem_write, flush, redirect, in_handler, double_fault;
  logic [31:0] redirect_pc, epc;
  logic [7:0]  cause, exc_count;

  exception_ctrl dut (
    .clk(clk), .rst_n(rst_n), .alu_status(alu_status), .status_valid(status_valid),
    .pc_in(pc_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .eret(eret),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .mem_read(mem_read), .mem_write(mem_write),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .in_handler(in_handler), .double_fault(double_fault), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr, mw, fl, rd, ih, df;
    logic [31:0] rpc, epc;
    logic [7:0]  cause, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: exception timeline expressed as cycle numbers.
  int          cyc = 0;
  bit          busy = 0;
  int          t_fault = 0;
  int          ret_at = -1;
  logic [7:0]  m_mask = 8'hFF, m_cause = '0, m_cnt = '0;
  logic [31:0] m_epc = '0, m_rpc = '0;
  bit          m_df = 0;

  task automatic model_reset();
    busy = 0; ret_at = -1; m_mask = 8'hFF; m_cause = '0; m_cnt = '0;
    m_epc = '0; m_rpc = '0; m_df = 0;
  endtask

  task automatic step(input logic rst, input logic [7:0] st, input logic vld,
                      input logic [31:0] pc, input logic rd, input logic wr,
                      input logic er, input logic we, input logic [7:0] cm);
    exp_t e;
    int   d;
    bit   p_idle, p_flush, p_vec, p_ret, p_hand, flt, pass;
    @(posedge clk);
    #1;
    rst_n = rst; alu_status = st; status_valid = vld; pc_in = pc;
    mem_read_in = rd; mem_write_in = wr; eret = er; cfg_we = we; cfg_mask = cm;
    if (!rst) begin
      model_reset();
      e = '{mr: 0, mw: 0, fl: 0, rd: 0, ih: 0, df: 0, rpc: '0, epc: '0, cause: '0, cnt: '0};
      exp_q.push_back(e);
      cyc++;
      return;
    end
    d       = cyc - t_fault;
    p_idle  = !busy;
    p_ret   = busy && (ret_at == cyc);
    p_flush = busy && d >= 1 && d <= F;
    p_vec   = busy && d == F + 1;
    p_hand  = busy && d > F + 1 && !p_ret;
    flt     = vld && ((st & FATAL & m_mask) != 8'h00);
    pass    = p_idle || p_hand;
    if (p_vec) m_rpc = VEC;
    else if (p_ret) m_rpc = m_epc + 32'd4;
    e.mr = rd && !flt && pass;
    e.mw = wr && !flt && pass;
    e.fl = p_flush;
    e.rd = p_vec || p_ret;
    e.rpc = m_rpc;
    e.ih = p_hand;
    e.df = m_df;
    e.epc = m_epc;
    e.cause = m_cause;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (p_idle && flt) begin
      m_epc = pc; m_cause = st & FATAL & m_mask;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      busy = 1; t_fault = cyc; ret_at = -1;
    end else if (flt) begin
      m_df = 1;
    end
    if (p_hand && er) ret_at = cyc + 1;
    if (p_ret) busy = 0;
    if (we) m_mask = cm;
    cyc++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: DUT outputs are valid every cycle; sample mid-cycle and retire the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_read", 32'(mem_read), 32'(e.mr));
        chk("mem_write", 32'(mem_write), 32'(e.mw));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("redirect", 32'(redirect), 32'(e.rd));
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("epc", epc, e.epc);
        chk("cause", 32'(cause), 32'(e.cause));
        chk("in_handler", 32'(in_handler), 32'(e.ih));
        chk("double_fault", 32'(double_fault), 32'(e.df));
        chk("exc_count", 32'(exc_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [7:0] st;
    int         guard;
    step(0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // pass-through, overflow fault with write, return via eret
    step(1, 8'h00, 1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1, 8'h40, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    quiet(4);
    step(1, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    quiet(2);
    // runtime mask drops bit 6, then bit 3 still faults
    step(1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBF);
    step(1, 8'h40, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1, 8'h08, 1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // fault during FLUSH, then eret together with a fault in HANDLER
    step(1, 8'h04, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    quiet(2);
    step(1, 8'h08, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    quiet(2);
    // reset mid-FLUSH
    step(1, 8'h04, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    quiet(1);
    // counter saturation: 260 full exception round trips, last pc wraps on return
    for (int i = 0; i < 260; i++) begin
      step(1, 8'h40, 1'b1, (i == 259) ? 32'hFFFF_FFFC : 32'(i * 8), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      quiet(3);
      step(1, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      quiet(1);
    end
    step(0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      st = 8'($urandom());
      if ($urandom_range(0, 3) != 0) st = st & ~FATAL;
      step(($urandom_range(0, 199) != 0), st, 1'($urandom()), $urandom() & 32'hFFFF_FFFC,
           1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0), 8'($urandom()));
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
